// File: rtl/banked_sram_pkg.sv
// Shared defaults, derived-width helpers and the read skid entry type for
// the banked SRAM controller.
package banked_sram_pkg;

    localparam int DEF_DATA_W     = 128;
    localparam int DEF_SLICE_W    = 32;
    localparam int DEF_ROWS       = 6;
    localparam int DEF_ROW_ADDR_W = 11;
    localparam int DEF_ADDR_W     = 32;

    // Number of macro columns needed to cover one access word.
    function automatic int calc_cols(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    // Width of the row-select field; a single row still gets one bit.
    function automatic int calc_row_sel_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    typedef struct packed {
        logic                  err;
        logic [DEF_DATA_W-1:0] data;
    } skid_entry_t;

endpackage

// File: rtl/sram_32_2048_freepdk45.sv
// Behavioural model of the 32x2048 single-port SRAM macro. Active-low chip
// select and write enable are sampled on the rising clock; read data is
// registered and holds until the next read of this macro.
module sram_32_2048_freepdk45 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Single port: a selected cycle is either a write or a read.
    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                mem[addr0] <= din0;
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

endmodule

// File: rtl/sram_rd_skid_buffer.sv
// Two-entry in-order buffer between the macro read pipeline and the read
// consumer. Output is taken straight from storage, so it holds steady while
// the consumer stalls.
module sram_rd_skid_buffer
    import banked_sram_pkg::*;
#(
    parameter type entry_t = skid_entry_t
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  entry_t     in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output entry_t     out_data,
    output logic [1:0] count
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       push;
    logic       pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/banked_sram_controller.sv
// Banked SRAM controller: ROWS x COLS single-port macros with one write and
// one read port. Accesses to different rows proceed in parallel; a write
// wins a same-row collision. Reads return in order through a 2-entry skid.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_RESET | first cycle after reset release, ports not ready
// ST_RUN   | normal operation, request ports ready
module banked_sram_controller
    import banked_sram_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SLICE_W    = DEF_SLICE_W,
    parameter int ROWS       = DEF_ROWS,
    parameter int ROW_ADDR_W = DEF_ROW_ADDR_W,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_req,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_d,
    output logic              w_done,
    output logic              w_err,
    input  logic              r_req,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_d,
    output logic              r_err,
    input  logic              r_d_ready
);

    localparam int COLS      = calc_cols(DATA_W, SLICE_W);
    localparam int ROW_SEL_W = calc_row_sel_w(ROWS);
    localparam int ADDR_USED = ROW_ADDR_W + ROW_SEL_W;
    localparam logic [ROW_SEL_W:0] ROWS_L = (ROW_SEL_W+1)'(ROWS);

    typedef enum logic {ST_RESET, ST_RUN} ctl_state_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rd_entry_t;

    ctl_state_t state_q;
    ctl_state_t state_d;
    logic       active;

    logic [ROW_SEL_W-1:0]  w_row;
    logic [ROW_SEL_W-1:0]  r_row;
    logic [ROW_ADDR_W-1:0] w_maddr;
    logic [ROW_ADDR_W-1:0] r_maddr;
    logic                  w_ok;
    logic                  r_ok;
    logic                  conflict;
    logic                  w_acc;
    logic                  r_acc;
    logic                  r_pop;
    logic [2:0]            rd_load;

    logic [ROWS-1:0]                 row_csb;
    logic [ROWS-1:0]                 row_web;
    logic [ROWS-1:0][ROW_ADDR_W-1:0] row_addr;
    logic [ROWS-1:0][DATA_W-1:0]     row_din;
    logic [ROWS-1:0][DATA_W-1:0]     row_dout;

    logic                 s1_valid;
    logic                 s1_err;
    logic [ROW_SEL_W-1:0] s1_row;
    logic                 s2_valid;
    logic                 s2_err;
    logic [ROW_SEL_W-1:0] s2_row;
    logic                 ws1_valid;
    logic                 ws1_err;
    logic                 ws2_valid;
    logic                 ws2_err;

    logic [DATA_W-1:0] rd_data;
    rd_entry_t         skid_in;
    rd_entry_t         skid_out;
    logic              skid_in_ready;
    logic              skid_out_valid;
    logic [1:0]        skid_count;
    logic              unused_addr;

    assign unused_addr = ^{w_addr[ADDR_W-1:ADDR_USED], r_addr[ADDR_W-1:ADDR_USED]};

    assign w_row   = w_addr[ROW_ADDR_W +: ROW_SEL_W];
    assign r_row   = r_addr[ROW_ADDR_W +: ROW_SEL_W];
    assign w_maddr = w_addr[ROW_ADDR_W-1:0];
    assign r_maddr = r_addr[ROW_ADDR_W-1:0];
    assign w_ok    = ({1'b0, w_row} < ROWS_L);
    assign r_ok    = ({1'b0, r_row} < ROWS_L);

    // Reads committed to the skid (pipeline + stored) net of this cycle's pop;
    // a new read is refused once two are already committed.
    assign r_pop    = skid_out_valid & r_d_ready;
    assign rd_load  = {2'b0, s1_valid} + {2'b0, s2_valid} + {1'b0, skid_count} - {2'b0, r_pop};
    assign conflict = w_req & r_req & (w_row == r_row);

    assign w_ready = active;
    assign r_ready = active & ~conflict & (rd_load < 3'd2);
    assign w_acc   = w_req & w_ready;
    assign r_acc   = r_req & r_ready;

    // Control state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    // Next state and ready enable.
    always_comb begin
        state_d = state_q;
        active  = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   active  = 1'b1;
            default:  state_d = ST_RESET;
        endcase
    end

    // Per-row macro select/write-enable, live only for the cycle after accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_csb <= '1;
            row_web <= '1;
        end else begin
            row_csb <= '1;
            row_web <= '1;
            for (int r = 0; r < ROWS; r++) begin
                if (w_acc && w_ok && (w_row == ROW_SEL_W'(r))) begin
                    row_csb[r] <= 1'b0;
                    row_web[r] <= 1'b0;
                end else if (r_acc && r_ok && (r_row == ROW_SEL_W'(r))) begin
                    row_csb[r] <= 1'b0;
                end
            end
        end
    end

    // Per-row macro address and write data; only meaningful while selected.
    always_ff @(posedge clock) begin
        for (int r = 0; r < ROWS; r++) begin
            if (w_acc && w_ok && (w_row == ROW_SEL_W'(r))) begin
                row_addr[r] <= w_maddr;
                row_din[r]  <= w_d;
            end else if (r_acc && r_ok && (r_row == ROW_SEL_W'(r))) begin
                row_addr[r] <= r_maddr;
            end
        end
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            sram_32_2048_freepdk45 #(
                .DATA_WIDTH(SLICE_W),
                .ADDR_WIDTH(ROW_ADDR_W)
            ) u_macro (
                .clk0 (clock),
                .csb0 (row_csb[gr]),
                .web0 (row_web[gr]),
                .addr0(row_addr[gr]),
                .din0 (row_din[gr][gc*SLICE_W +: SLICE_W]),
                .dout0(row_dout[gr][gc*SLICE_W +: SLICE_W])
            );
        end
    end

    // Read and write completion pipelines, two stages to match macro timing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_row    <= '0;
            s2_valid  <= 1'b0;
            s2_err    <= 1'b0;
            s2_row    <= '0;
            ws1_valid <= 1'b0;
            ws1_err   <= 1'b0;
            ws2_valid <= 1'b0;
            ws2_err   <= 1'b0;
            w_done    <= 1'b0;
            w_err     <= 1'b0;
        end else begin
            s1_valid  <= r_acc;
            s1_err    <= ~r_ok;
            s1_row    <= r_row;
            s2_valid  <= s1_valid;
            s2_err    <= s1_err;
            s2_row    <= s1_row;
            ws1_valid <= w_acc;
            ws1_err   <= ~w_ok;
            ws2_valid <= ws1_valid;
            ws2_err   <= ws1_err;
            w_done    <= ws2_valid;
            w_err     <= ws2_valid & ws2_err;
        end
    end

    // Pick the row whose macros just produced read data; out-of-range reads return zero.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (s2_row == ROW_SEL_W'(r)) rd_data = row_dout[r];
        end
        skid_in.err  = s2_err;
        skid_in.data = s2_err ? '0 : rd_data;
    end

    sram_rd_skid_buffer #(
        .entry_t(rd_entry_t)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .in_valid (s2_valid),
        .in_ready (skid_in_ready),
        .in_data  (skid_in),
        .out_valid(skid_out_valid),
        .out_ready(r_d_ready),
        .out_data (skid_out),
        .count    (skid_count)
    );

    // Admission control must leave room for every read already in the pipe.
    assert property (@(posedge clock) disable iff (!reset) s2_valid |-> skid_in_ready);

    assign r_valid = skid_out_valid;
    assign r_err   = skid_out_valid & skid_out.err;
    assign r_d     = skid_out_valid ? skid_out.data : '0;

endmodule

// File: tb/tb_banked_sram_controller.sv
// Directed and randomized bench for banked_sram_controller against a
// queue-based model of the port behaviour.
module tb_banked_sram_controller;

    localparam int DW = 128;
    localparam int NR = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          w_req = 1'b0;
    logic          w_ready;
    logic [31:0]   w_addr = '0;
    logic [DW-1:0] w_d = '0;
    logic          w_done;
    logic          w_err;
    logic          r_req = 1'b0;
    logic          r_ready;
    logic [31:0]   r_addr = '0;
    logic          r_valid;
    logic [DW-1:0] r_d;
    logic          r_err;
    logic          r_d_ready = 1'b1;

    banked_sram_controller dut (
        .clock    (clock),
        .reset    (reset),
        .w_req    (w_req),
        .w_ready  (w_ready),
        .w_addr   (w_addr),
        .w_d      (w_d),
        .w_done   (w_done),
        .w_err    (w_err),
        .r_req    (r_req),
        .r_ready  (r_ready),
        .r_addr   (r_addr),
        .r_valid  (r_valid),
        .r_d      (r_d),
        .r_err    (r_err),
        .r_d_ready(r_d_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] d;
        bit            err;
        bit            known;
        int            due;
    } rd_t;

    typedef struct {
        bit err;
        int due;
    } wd_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    bit            active_m = 1'b0;
    bit            last_racc = 1'b0;
    logic [NR-1:0] exp_csb = '1;
    logic [NR-1:0] exp_web = '1;
    rd_t           rd_q[$];
    wd_t           wd_q[$];
    logic [DW-1:0] mem_m [int];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int row, input int maddr);
        return (32'(row) << 11) | 32'(maddr);
    endfunction

    function automatic bit model_rvalid();
        return (rd_q.size() > 0) && (rd_q[0].due <= cyc);
    endfunction

    function automatic bit model_rready();
        bit same_row;
        int pend;
        same_row = w_req && r_req && (w_addr[13:11] == r_addr[13:11]);
        pend = rd_q.size() - ((model_rvalid() && r_d_ready) ? 1 : 0);
        return active_m && !same_row && (pend < 2);
    endfunction

    // One clock: check outputs for the current cycle, then advance the model.
    task automatic tick();
        bit ev, er, wa, ra, pop;
        int wrow, rrow;
        rd_t e;
        #2;
        ev = model_rvalid();
        er = model_rready();
        chk("w_ready", w_ready, active_m);
        chk("r_ready", r_ready, er);
        chk("r_valid", r_valid, ev);
        if (ev) begin
            chk("r_err", r_err, rd_q[0].err);
            if (rd_q[0].known) chk("r_d", r_d, rd_q[0].d);
        end
        if (wd_q.size() > 0 && wd_q[0].due == cyc) begin
            chk("w_done", w_done, 1'b1);
            chk("w_err", w_err, wd_q[0].err);
            void'(wd_q.pop_front());
        end else begin
            chk("w_done_idle", w_done, 1'b0);
        end
        chk("row_csb", dut.row_csb, exp_csb);
        chk("row_web", dut.row_web, exp_web);
        wa  = active_m && w_req;
        ra  = r_req && er;
        pop = ev && r_d_ready;
        wrow = int'(w_addr[13:11]);
        rrow = int'(r_addr[13:11]);
        @(posedge clock);
        cyc++;
        exp_csb = '1;
        exp_web = '1;
        last_racc = 1'b0;
        if (reset) begin
            if (pop) void'(rd_q.pop_front());
            if (wa) begin
                if (wrow < NR) begin
                    mem_m[int'(w_addr[13:0])] = w_d;
                    exp_csb[wrow] = 1'b0;
                    exp_web[wrow] = 1'b0;
                end
                wd_q.push_back('{err: (wrow >= NR), due: cyc + 2});
            end
            if (ra) begin
                e.due = cyc + 2;
                e.err = (rrow >= NR);
                e.known = 1'b1;
                e.d = '0;
                if (rrow < NR) begin
                    exp_csb[rrow] = 1'b0;
                    if (mem_m.exists(int'(r_addr[13:0]))) e.d = mem_m[int'(r_addr[13:0])];
                    else e.known = 1'b0;
                end
                rd_q.push_back(e);
                last_racc = 1'b1;
            end
        end
        active_m = reset;
        #1;
    endtask

    task automatic idle(input int n);
        w_req = 1'b0;
        r_req = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset(input int hold);
        reset = 1'b0;
        w_req = 1'b0;
        r_req = 1'b0;
        #1;
        rd_q.delete();
        wd_q.delete();
        active_m = 1'b0;
        exp_csb = '1;
        exp_web = '1;
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_r_err", r_err, 1'b0);
        chk("rst_w_done", w_done, 1'b0);
        chk("rst_w_err", w_err, 1'b0);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_r_ready", r_ready, 1'b0);
        chk("rst_csb", dut.row_csb, exp_csb);
        chk("rst_web", dut.row_web, exp_web);
        for (int i = 0; i < hold; i++) tick();
        reset = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d);
        w_req = 1'b1;
        w_addr = a;
        w_d = d;
        tick();
        w_req = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        int k;
        r_req = 1'b1;
        r_addr = a;
        k = 0;
        do begin
            tick();
            k++;
        end while (!last_racc && k < 40);
        r_req = 1'b0;
        if (!last_racc) chk("read_accept_timeout", 1'b0, 1'b1);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [31:0] rd_addrs [4];
    int          idx;

    initial begin
        #1;
        apply_reset(2);
        idle(3);

        // Basic write then read back at 0x0805.
        do_write(32'h0000_0805, {16{8'hA5}});
        idle(3);
        do_read(32'h0000_0805);
        idle(3);

        // Parallel write row 1 and read row 3.
        do_write(mk_addr(3, 16), rnd_data());
        idle(3);
        w_req = 1'b1; w_addr = mk_addr(1, 7); w_d = rnd_data();
        r_req = 1'b1; r_addr = mk_addr(3, 16);
        tick();
        idle(4);

        // Same-row collision on row 2: write wins, read follows a cycle later.
        do_write(mk_addr(2, 4), rnd_data());
        idle(3);
        w_req = 1'b1; w_addr = mk_addr(2, 8); w_d = rnd_data();
        r_req = 1'b1; r_addr = mk_addr(2, 4);
        tick();
        w_req = 1'b0;
        tick();
        idle(5);

        // Four back-to-back reads against a stalled consumer, then release.
        rd_addrs[0] = 32'h0000_0805;
        rd_addrs[1] = mk_addr(3, 16);
        rd_addrs[2] = mk_addr(2, 4);
        rd_addrs[3] = mk_addr(1, 7);
        idx = 0;
        r_d_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            r_req = (idx < 4);
            r_addr = rd_addrs[idx % 4];
            tick();
            if (last_racc) idx++;
        end
        r_d_ready = 1'b1;
        for (int k = 0; k < 30 && idx < 4; k++) begin
            r_req = 1'b1;
            r_addr = rd_addrs[idx];
            tick();
            if (last_racc) idx++;
        end
        if (idx < 4) chk("stall_read_timeout", 1'b0, 1'b1);
        idle(6);

        // Out-of-range rows: write row 7, read row 6.
        do_write(mk_addr(7, 3), rnd_data());
        idle(3);
        do_read(mk_addr(6, 1));
        idle(4);

        // Write then read immediately on the next edge.
        do_write(mk_addr(4, 9), rnd_data());
        do_read(mk_addr(4, 9));
        idle(4);

        // Reset with two reads in flight.
        r_req = 1'b1; r_addr = 32'h0000_0805;
        tick();
        r_addr = mk_addr(3, 16);
        tick();
        apply_reset(3);
        idle(4);
        do_write(mk_addr(5, 2), {4{32'h1234_5678}});
        do_read(mk_addr(5, 2));
        idle(4);

        // Randomized traffic over a small address set.
        for (int k = 0; k < 400; k++) begin
            w_req = ($urandom_range(0, 1) == 1);
            w_addr = {$urandom_range(0, 255), 2'b00, 3'($urandom_range(0, 7)), 9'd0, 2'($urandom_range(0, 3))};
            w_d = rnd_data();
            r_req = ($urandom_range(0, 2) != 0);
            r_addr = {$urandom_range(0, 255), 2'b00, 3'($urandom_range(0, 7)), 9'd0, 2'($urandom_range(0, 3))};
            r_d_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        r_d_ready = 1'b1;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
